sobol_stream: RTL and testbench

SOBOL_STREAM -- requirements
Module: sobol_stream

---
 rtl/sobol_stream.sv | 150 +++++++++++++++
 tb/tb_sobol_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobol_stream.sv
// sobol_stream: streams M-dimensional Sobol points in Gray-code order, one 0.32 coordinate per cycle.
// Optional macro SOBOL_SKIP_ZERO_EN starts the sequence at index 1, skipping the all-zero point.
module sobol_stream #(
  parameter int M = 12,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          num_points,
  output logic                 busy,
  input  logic                 dir_we,
  input  logic [$clog2(M)-1:0] dir_dim,
  input  logic [4:0]           dir_bit,
  input  logic [W-1:0]         dir_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(M)-1:0] out_dim,
  output logic [31:0]          out_index,
  output logic                 out_last
);
  localparam int DW = $clog2(M);
  localparam logic [DW-1:0] DIM_LAST = DW'(M - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;
`ifdef SOBOL_SKIP_ZERO_EN
  localparam logic [31:0] START_IDX = 32'd1;
`else
  localparam logic [31:0] START_IDX = 32'd0;
`endif

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] dim_q, dim_d;
  logic [31:0]   index_q, index_d;
  logic [31:0]   last_idx_q, last_idx_d;

  logic          start_acc;
  logic          dir_wr;
  logic          accept;
  logic          dim_end;
  logic          is_last;
  logic [31:0]   idx_inc;
  logic [4:0]    ctz;
  logic [W-1:0]  x_all [M];

  assign start_acc = (state_q == S_IDLE) && start && (num_points != 32'd0);
  assign dir_wr    = dir_we && (state_q == S_IDLE) && (32'(dir_dim) < M);
  assign accept    = (state_q == S_EMIT) && out_ready;
  assign dim_end   = (dim_q == DIM_LAST);
  assign is_last   = dim_end && (index_q == last_idx_q);
  assign idx_inc   = index_q + 32'd1;

  // Trailing-zero count of i+1 selects which direction number flips this step.
  always_comb begin
    ctz = 5'd0;
    for (int k = 31; k >= 0; k--) begin
      if (idx_inc[k]) ctz = 5'(k);
    end
  end

  always_comb begin
    state_d    = state_q;
    dim_d      = dim_q;
    index_d    = index_q;
    last_idx_d = last_idx_q;
    if (start_acc) begin
      state_d = S_EMIT;
      dim_d   = '0;
      index_d = START_IDX;
`ifdef SOBOL_SKIP_ZERO_EN
      last_idx_d = num_points;
`else
      last_idx_d = num_points - 32'd1;
`endif
    end else if (accept) begin
      if (is_last) begin
        state_d = S_IDLE;
      end else if (dim_end) begin
        dim_d   = '0;
        index_d = idx_inc;
      end else begin
        dim_d = dim_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dim_q      <= '0;
      index_q    <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      dim_q      <= dim_d;
      index_q    <= index_d;
      last_idx_q <= last_idx_d;
    end
  end

  generate
    for (genvar gi = 0; gi < M; gi++) begin : gen_dim
      logic [W-1:0] v_q [32];
      logic [W-1:0] x_q, x_d;
      logic         hit_dim;

      assign hit_dim = dir_wr && (dir_dim == DW'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < 32; k++) begin
            v_q[k] <= W'(32'h8000_0000 >> k);
          end
        end else if (hit_dim) begin
          v_q[dir_bit] <= dir_data;
        end
      end

      always_comb begin
        x_d = x_q;
        if (start_acc) begin
`ifdef SOBOL_SKIP_ZERO_EN
          // A same-cycle write to v[gi][0] must already be visible in the first point.
          x_d = (hit_dim && (dir_bit == 5'd0)) ? dir_data : v_q[0];
`else
          x_d = '0;
`endif
        end else if (accept && (dim_q == DW'(gi))) begin
          x_d = x_q ^ v_q[ctz];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) x_q <= '0;
        else     x_q <= x_d;
      end

      assign x_all[gi] = x_q;
    end
  endgenerate

  assign busy      = (state_q == S_EMIT);
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = x_all[dim_q];
  assign out_dim   = dim_q;
  assign out_index = index_q;
  assign out_last  = (state_q == S_EMIT) && is_last;

endmodule

// File: tb/tb_sobol_stream.sv
// Scoreboard bench for sobol_stream: directed sequences push hand-computed words, a monitor pops and compares.
module tb_sobol_stream;
  localparam int M  = 12;
  localparam int DW = $clog2(M);
`ifdef SOBOL_SKIP_ZERO_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   num_points;
  logic          busy;
  logic          dir_we;
  logic [DW-1:0] dir_dim;
  logic [4:0]    dir_bit;
  logic [31:0]   dir_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [DW-1:0] out_dim;
  logic [31:0]   out_index;
  logic          out_last;

  typedef struct packed {
    logic [31:0]   data;
    logic [DW-1:0] dim;
    logic [31:0]   index;
    logic          last;
  } word_t;

  word_t exp_q[$];
  int    errors   = 0;
  int    checks   = 0;
  int    accepted = 0;
  logic  hold_pend = 1'b0;
  word_t hold_w;

  sobol_stream #(.M(M), .W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_points(num_points), .busy(busy),
    .dir_we(dir_we), .dir_dim(dir_dim), .dir_bit(dir_bit), .dir_data(dir_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dim(out_dim), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Hand-computed coordinates: default van der Corput table, plus v[3][0]=12345678 and v[5][0]=0F0F0F0F when mod.
  function automatic logic [31:0] exp_val(int idx, int d, bit mod);
    logic [31:0] vdc [5];
    vdc[0] = 32'h0000_0000; vdc[1] = 32'h8000_0000; vdc[2] = 32'hC000_0000;
    vdc[3] = 32'h4000_0000; vdc[4] = 32'h6000_0000;
    if (mod && d == 3 && idx == 1) return 32'h1234_5678;
    if (mod && d == 3 && idx == 2) return 32'h5234_5678;
    if (mod && d == 5 && idx == 1) return 32'h0F0F_0F0F;
    if (mod && d == 5 && idx == 2) return 32'h4F0F_0F0F;
    return vdc[idx];
  endfunction

  task automatic push_seq(input int n, input bit mod);
    word_t w;
    for (int i = BASE; i < BASE + n; i++) begin
      for (int d = 0; d < M; d++) begin
        w.data  = exp_val(i, d, mod);
        w.dim   = DW'(d);
        w.index = 32'(i);
        w.last  = (i == BASE + n - 1) && (d == M - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic do_start(input logic [31:0] n);
    @(posedge clk); #1;
    start = 1'b1; num_points = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic dir_write(input int d, input int b, input logic [31:0] data);
    @(posedge clk); #1;
    dir_we = 1'b1; dir_dim = DW'(d); dir_bit = 5'(b); dir_data = data;
    @(posedge clk); #1;
    dir_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d required busy=0 pending=0", name, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops one expected word per accepted output and checks holding while stalled.
  always @(negedge clk) begin
    word_t got;
    word_t exp_w;
    got.data = out_data; got.dim = out_dim; got.index = out_index; got.last = out_last;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (got !== hold_w || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL hold: got data=%h dim=%0d idx=%0d valid=%0b required data=%h dim=%0d idx=%0d valid=1",
                   got.data, got.dim, got.index, out_valid, hold_w.data, hold_w.dim, hold_w.index);
        end
      end
      if (out_valid && out_ready) begin
        accepted++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h dim=%0d idx=%0d required no word", got.data, got.dim, got.index);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin
            errors++;
            $display("FAIL word: got data=%h dim=%0d idx=%0d last=%0b required data=%h dim=%0d idx=%0d last=%0b",
                     got.data, got.dim, got.index, got.last, exp_w.data, exp_w.dim, exp_w.index, exp_w.last);
          end else begin
            $display("word idx=%0d dim=%0d data=%h last=%0b ok", got.index, got.dim, got.data, got.last);
          end
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_w    = got;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    bit seen;
    rst = 1'b1; start = 1'b0; num_points = '0; dir_we = 1'b0;
    dir_dim = '0; dir_bit = '0; dir_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_dim", 32'(out_dim), 32'd0);
    chk("rst_index", out_index, 32'd0);
    rst = 1'b0;

    // Default table, 4 points, consumer always ready.
    acc0 = accepted;
    push_seq(4, 1'b0);
    do_start(32'd4);
    wait_idle("seq4");
    chk("seq4_count", 32'(accepted - acc0), 32'd48);

    // Back-pressure: ready goes 1-0-0-1 mid-sequence.
    acc0 = accepted;
    push_seq(4, 1'b0);
    do_start(32'd4);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle("stall");
    chk("stall_count", 32'(accepted - acc0), 32'd48);

    // Table writes: one in IDLE, one together with start, one during EMIT that must be dropped.
    dir_write(3, 0, 32'h1234_5678);
    push_seq(2, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; num_points = 32'd2;
    dir_we = 1'b1; dir_dim = DW'(5); dir_bit = 5'd0; dir_data = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    start = 1'b0;
    dir_dim = DW'(0); dir_bit = 5'd0; dir_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dir_we = 1'b0;
    wait_idle("dirw");

    // Zero-length start is ignored; a start while busy is ignored.
    do_start(32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_valid", 32'(out_valid), 32'd0);
    end
    acc0 = accepted;
    push_seq(1, 1'b1);
    do_start(32'd1);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; num_points = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("busy_start");
    repeat (10) @(negedge clk);
    chk("busy_start_count", 32'(accepted - acc0), 32'd12);
    chk("busy_start_idle", 32'(busy), 32'd0);

    // Reset during index BASE+2 aborts at once and restores the default table.
    push_seq(4, 1'b1);
    do_start(32'd4);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 32'(BASE + 2) && out_dim == '0) seen = 1'b1;
    end
    chk("rst_mid_reached", 32'(seen), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_last", 32'(out_last), 32'd0);
    chk("rst_mid_index", out_index, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_quiet", 32'(out_valid), 32'd0);
    acc0 = accepted;
    push_seq(2, 1'b0);
    do_start(32'd2);
    wait_idle("restart");
    chk("restart_count", 32'(accepted - acc0), 32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
